// File: rtl/local_mem_result_bank.sv
// Multi-entry signed result store: overwrite or accumulate writes, registered reads,
// and a sequencer that zeroes every entry one per cycle between layers.
module local_mem_result_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_result_signal,
    input  logic [ADDR_W-1:0] read_result_addr,
    input  logic              write_result_signal,
    input  logic [ADDR_W-1:0] write_result_addr,
    input  logic [DATA_W-1:0] write_result_data,
    input  logic              write_result_mode,
    input  logic              clear_start,
    output logic [DATA_W-1:0] read_result_data,
    output logic              read_result_valid,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              acc_overflow
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_reg;
    logic [ADDR_W-1:0] ptr_reg;

    logic              rd_in_range;
    logic              wr_in_range;
    logic              wr_en;
    logic [DATA_W-1:0] wr_cur;
    logic [DATA_W:0]   wr_sum;
    logic              wr_ovf;
    logic [DATA_W-1:0] wr_next;

    assign rd_in_range = {1'b0, read_result_addr}  < DEPTH_L;
    assign wr_in_range = {1'b0, write_result_addr} < DEPTH_L;
    // A clear request in the same cycle takes priority over any write.
    assign wr_en = (state_reg == IDLE) && write_result_signal && !clear_start && wr_in_range;

    always_comb begin
        wr_cur  = wr_in_range ? mem[write_result_addr] : '0;
        wr_sum  = {wr_cur[DATA_W-1], wr_cur} + {write_result_data[DATA_W-1], write_result_data};
        wr_ovf  = write_result_mode && (wr_sum[DATA_W] != wr_sum[DATA_W-1]);
        wr_next = write_result_data;
        if (write_result_mode) begin
            if (wr_ovf && (SAT_EN != 0)) begin
                wr_next = wr_sum[DATA_W] ? SAT_MIN : SAT_MAX;
            end else begin
                wr_next = wr_sum[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state_reg         <= IDLE;
            ptr_reg           <= '0;
            read_result_data  <= '0;
            read_result_valid <= 1'b0;
            clear_busy        <= 1'b0;
            clear_done        <= 1'b0;
            acc_overflow      <= 1'b0;
        end else begin
            // Reads sample the array before this edge's update: read-before-write.
            read_result_valid <= read_result_signal;
            if (read_result_signal && (state_reg == IDLE) && rd_in_range) begin
                read_result_data <= mem[read_result_addr];
            end else begin
                read_result_data <= '0;
            end

            clear_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear_start) begin
                        state_reg    <= CLEAR;
                        ptr_reg      <= '0;
                        clear_busy   <= 1'b1;
                        acc_overflow <= 1'b0;
                    end else if (wr_en) begin
                        mem[write_result_addr] <= wr_next;
                        if (wr_ovf) begin
                            acc_overflow <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    mem[ptr_reg] <= '0;
                    if (ptr_reg == PTR_LAST) begin
                        state_reg  <= IDLE;
                        ptr_reg    <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_local_mem_result_bank.sv
// Directed bench for local_mem_result_bank with default parameters (32-bit, 16 entries, saturating).
module tb_local_mem_result_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_result_signal;
    logic [3:0]  read_result_addr;
    logic        write_result_signal;
    logic [3:0]  write_result_addr;
    logic [31:0] write_result_data;
    logic        write_result_mode;
    logic        clear_start;
    logic [31:0] read_result_data;
    logic        read_result_valid;
    logic        clear_busy;
    logic        clear_done;
    logic        acc_overflow;

    int tests_run = 0;
    int tests_failed = 0;
    int busy_cycles;

    local_mem_result_bank dut (
        .clk                 (clk),
        .rst                 (rst),
        .read_result_signal  (read_result_signal),
        .read_result_addr    (read_result_addr),
        .write_result_signal (write_result_signal),
        .write_result_addr   (write_result_addr),
        .write_result_data   (write_result_data),
        .write_result_mode   (write_result_mode),
        .clear_start         (clear_start),
        .read_result_data    (read_result_data),
        .read_result_valid   (read_result_valid),
        .clear_busy          (clear_busy),
        .clear_done          (clear_done),
        .acc_overflow        (acc_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        read_result_signal  = 1'b0;
        read_result_addr    = '0;
        write_result_signal = 1'b0;
        write_result_addr   = '0;
        write_result_data   = '0;
        write_result_mode   = 1'b0;
        clear_start         = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic m);
        write_result_signal = 1'b1;
        write_result_addr   = a;
        write_result_data   = d;
        write_result_mode   = m;
        tick();
        write_result_signal = 1'b0;
        $display("[TB] write addr=%0d data=0x%08h mode=%0d", a, d, m);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        read_result_signal = 1'b1;
        read_result_addr   = a;
        tick();
        read_result_signal = 1'b0;
        $display("[TB] read  addr=%0d data=0x%08h valid=%0d", a, read_result_data, read_result_valid);
        check({tag, "_valid"}, {31'd0, read_result_valid}, 32'd1);
        check({tag, "_data"}, read_result_data, exp);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        check("rst_data",  read_result_data, 32'd0);
        check("rst_valid", {31'd0, read_result_valid}, 32'd0);
        check("rst_busy",  {31'd0, clear_busy}, 32'd0);
        check("rst_done",  {31'd0, clear_done}, 32'd0);
        check("rst_ovf",   {31'd0, acc_overflow}, 32'd0);
        rst = 1'b1;

        // 1: read after reset, then an idle cycle
        do_read("t1_rd3", 4'd3, 32'd0);
        tick();
        check("t1_idle_valid", {31'd0, read_result_valid}, 32'd0);
        check("t1_idle_data",  read_result_data, 32'd0);

        // 2: overwrite then accumulate a negative
        do_write(4'd5, 32'd100, 1'b0);
        do_write(4'd5, -32'sd30, 1'b1);
        do_read("t2_rd5", 4'd5, 32'd70);
        check("t2_ovf", {31'd0, acc_overflow}, 32'd0);

        // 3: positive and negative saturation
        do_write(4'd0, 32'h7FFF_FFF0, 1'b0);
        do_write(4'd0, 32'h0000_0020, 1'b1);
        do_read("t3_pos_sat", 4'd0, 32'h7FFF_FFFF);
        check("t3_ovf", {31'd0, acc_overflow}, 32'd1);
        do_write(4'd1, 32'h8000_0010, 1'b0);
        do_write(4'd1, 32'hFFFF_FFE0, 1'b1);
        do_read("t3_neg_sat", 4'd1, 32'h8000_0000);

        // 4: read and write to the same address in one cycle
        do_write(4'd2, 32'd4, 1'b0);
        write_result_signal = 1'b1;
        write_result_addr   = 4'd2;
        write_result_data   = 32'd9;
        write_result_mode   = 1'b0;
        do_read("t4_same_cycle", 4'd2, 32'd4);
        write_result_signal = 1'b0;
        do_read("t4_after", 4'd2, 32'd9);

        // 5: fill, then clear; an accumulate that would overflow is issued with clear_start
        for (int i = 1; i < 16; i++) begin
            do_write(4'(i), 32'(i + 1), 1'b0);
        end
        do_write(4'd0, 32'h7FFF_FFFF, 1'b0);
        do_read("t5_fill15", 4'd15, 32'd16);
        clear_start         = 1'b1;
        write_result_signal = 1'b1;
        write_result_addr   = 4'd0;
        write_result_data   = 32'd1;
        write_result_mode   = 1'b1;
        tick();
        idle_inputs();
        busy_cycles = 0;
        for (int c = 0; c < 40 && clear_busy; c++) begin
            busy_cycles++;
            if (busy_cycles == 3) begin
                read_result_signal = 1'b1;
                read_result_addr   = 4'd15;
            end
            if (busy_cycles == 5) clear_start = 1'b1;
            if (busy_cycles == 10) begin
                write_result_signal = 1'b1;
                write_result_addr   = 4'd0;
                write_result_data   = 32'd77;
            end
            tick();
            if (busy_cycles == 3) begin
                check("t5_rd_in_clear_valid", {31'd0, read_result_valid}, 32'd1);
                check("t5_rd_in_clear_data",  read_result_data, 32'd0);
            end
            idle_inputs();
        end
        $display("[TB] clear busy_cycles=%0d done=%0d", busy_cycles, clear_done);
        check("t5_busy_cycles", 32'(busy_cycles), 32'd16);
        check("t5_done_pulse",  {31'd0, clear_done}, 32'd1);
        check("t5_ovf_cleared", {31'd0, acc_overflow}, 32'd0);
        tick();
        check("t5_done_low", {31'd0, clear_done}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_read("t5_cleared", 4'(i), 32'd0);
        end

        // 6: reset during the fifth clear cycle
        for (int i = 8; i < 16; i++) begin
            do_write(4'(i), 32'(100 + i), 1'b0);
        end
        do_write(4'd12, 32'h7FFF_FFFF, 1'b0);
        do_write(4'd12, 32'd5, 1'b1);
        check("t6_ovf_set", {31'd0, acc_overflow}, 32'd1);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("t6_busy_start", {31'd0, clear_busy}, 32'd1);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_busy_reset", {31'd0, clear_busy}, 32'd0);
        check("t6_done_reset", {31'd0, clear_done}, 32'd0);
        check("t6_ovf_reset",  {31'd0, acc_overflow}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t6_no_done", {31'd0, clear_done}, 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            do_read("t6_zero", 4'(i), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
